dm163_scan_controller: RTL

- Row-scan sequencer for the 8x8 RGB colorshield driven by a DM163 constant-current driver.
- Per row: fetches 8 pixels from the frame buffer, serialises 192 bits into the DM163, pulses its latch, then lights the row.
- Drives `row_sel` into the existing 3-to-8 one-hot row encoder; `row_en` gates the encoder output.

---
 rtl/dm163_scan_controller.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dm163_scan_controller.sv
// Row-scan sequencer for an 8x8 RGB shield behind a DM163 driver: fetch 8 pixels, shift 192 bits, latch, light row.
// Optional power-up dot-correction load is built when DM163_DC_INIT_EN is defined.
module dm163_scan_controller #(
  parameter int         ON_CYCLES  = 1024,
  parameter int         LAT_CYCLES = 2
`ifdef DM163_DC_INIT_EN
  ,
  parameter logic [5:0] DC_VALUE   = 6'h3F
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [5:0]  rd_addr,
  input  logic [23:0] rd_data,
  output logic        sck,
  output logic        sda,
  output logic        lat,
  output logic        sb,
  output logic        dm_rst_n,
  output logic [2:0]  row_sel,
  output logic        row_en,
  output logic        frame_done,
  output logic [2:0]  dbg_state
);

  localparam int CNT_MAX = (ON_CYCLES > LAT_CYCLES) ? ON_CYCLES : LAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef DM163_DC_INIT_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHIFT    = 3'd2,
    S_LATCH    = 3'd3,
    S_DISPLAY  = 3'd4,
    S_DC_SHIFT = 3'd5,
    S_DC_LATCH = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SHIFT   = 3'd2,
    S_LATCH   = 3'd3,
    S_DISPLAY = 3'd4
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic              r_half;
  logic [4:0]        r_bit;
  logic [23:0]       r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_row_sel;
  logic              r_row_en;
  logic              r_dm_rst_n;
  logic              w_bit_done;
  logic              w_lat_done;
  logic              w_on_done;
`ifdef DM163_DC_INIT_EN
  logic              r_dc_done;
  logic [5:0]        r_dc_pat;
  logic [7:0]        r_dc_bit;
  logic              w_dc_shift_done;
`endif

  assign w_bit_done = r_half && (r_bit == 5'd23);
  assign w_lat_done = (r_cnt == CNT_W'(LAT_CYCLES - 1));
  assign w_on_done  = (r_cnt == CNT_W'(ON_CYCLES - 1));
`ifdef DM163_DC_INIT_EN
  assign w_dc_shift_done = r_half && (r_dc_bit == 8'd143);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state plus the directly decoded DM163/frame-buffer outputs.
  always_comb begin
    w_next_state = r_state;
    rd_addr      = 6'd0;
    sck          = 1'b0;
    sda          = 1'b0;
    lat          = 1'b0;
    sb           = 1'b1;
    frame_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef DM163_DC_INIT_EN
        if (!r_dc_done)  w_next_state = S_DC_SHIFT;
        else if (enable) w_next_state = S_FETCH;
`else
        if (enable) w_next_state = S_FETCH;
`endif
      end
      S_FETCH: begin
        rd_addr = {r_row, r_col};
        if (r_half) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        sck = r_half;
        sda = r_shift[23];
        if (w_bit_done) w_next_state = (r_col != 3'd0) ? S_FETCH : S_LATCH;
      end
      S_LATCH: begin
        lat = 1'b1;
        if (w_lat_done) w_next_state = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (w_on_done) begin
          frame_done   = (r_row == 3'd7);
          w_next_state = enable ? S_FETCH : S_IDLE;
        end
      end
`ifdef DM163_DC_INIT_EN
      S_DC_SHIFT: begin
        sb  = 1'b0;
        sck = r_half;
        sda = r_dc_pat[5];
        if (w_dc_shift_done) w_next_state = S_DC_LATCH;
      end
      S_DC_LATCH: begin
        sb  = 1'b0;
        lat = 1'b1;
        if (w_lat_done) w_next_state = S_IDLE;
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= 3'd0;
      r_col      <= 3'd7;
      r_half     <= 1'b0;
      r_bit      <= 5'd0;
      r_shift    <= 24'd0;
      r_cnt      <= '0;
      r_row_sel  <= 3'd0;
      r_row_en   <= 1'b0;
      r_dm_rst_n <= 1'b0;
`ifdef DM163_DC_INIT_EN
      r_dc_done  <= 1'b0;
      r_dc_pat   <= 6'd0;
      r_dc_bit   <= 8'd0;
`endif
    end else begin
      r_dm_rst_n <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_col  <= 3'd7;
          r_half <= 1'b0;
`ifdef DM163_DC_INIT_EN
          if (!r_dc_done) begin
            r_dc_pat <= DC_VALUE;
            r_dc_bit <= 8'd0;
          end
`endif
        end
        S_FETCH: begin
          r_half <= ~r_half;
          if (r_half) begin
            r_shift <= rd_data;
            r_bit   <= 5'd0;
          end
        end
        S_SHIFT: begin
          r_half <= ~r_half;
          if (r_half) begin
            r_shift <= {r_shift[22:0], 1'b0};
            r_bit   <= r_bit + 5'd1;
            if (r_bit == 5'd23) begin
              if (r_col != 3'd0) begin
                r_col <= r_col - 3'd1;
              end else begin
                // Blank the old row while the new data is latched in.
                r_col     <= 3'd7;
                r_row_sel <= r_row;
                r_row_en  <= 1'b0;
                r_cnt     <= '0;
              end
            end
          end
        end
        S_LATCH: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_lat_done) begin
            r_cnt    <= '0;
            r_row_en <= 1'b1;
          end
        end
        S_DISPLAY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_on_done) begin
            r_cnt <= '0;
            r_row <= r_row + 3'd1;
            if (w_next_state == S_IDLE) begin
              r_row     <= 3'd0;
              r_row_sel <= 3'd0;
              r_row_en  <= 1'b0;
            end
          end
        end
`ifdef DM163_DC_INIT_EN
        S_DC_SHIFT: begin
          r_half <= ~r_half;
          if (r_half) begin
            r_dc_pat <= {r_dc_pat[4:0], r_dc_pat[5]};
            r_dc_bit <= r_dc_bit + 8'd1;
            if (w_dc_shift_done) r_cnt <= '0;
          end
        end
        S_DC_LATCH: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_lat_done) begin
            r_cnt     <= '0;
            r_dc_done <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign row_sel   = r_row_sel;
  assign row_en    = r_row_en;
  assign dm_rst_n  = r_dm_rst_n;
  assign dbg_state = r_state;

endmodule
